msg_len_queue: RTL

MSG_LEN_QUEUE -- requirements
Module: msg_len_queue

---
 rtl/msg_len_if.sv | 25 ++
 rtl/msg_len_queue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/msg_len_if.sv
// Stream-monitor and length-output handshake bundle for msg_len_queue.
// The slave modport is the DUT's view, and the master modport is the environment's view.
`timescale 1ns/1ps
interface msg_len_if #(
  parameter int TKEEP_WIDTH = 8
);
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [TKEEP_WIDTH-1:0] s_tkeep;
  logic                   m_len_tvalid;
  logic                   m_len_tready;
  logic [15:0]            m_len_tdata;
  logic                   m_len_tuser;

  modport master (
    output s_tvalid, s_tready, s_tlast, s_tkeep, m_len_tready,
    input  m_len_tvalid, m_len_tdata, m_len_tuser
  );

  modport slave (
    input  s_tvalid, s_tready, s_tlast, s_tkeep, m_len_tready,
    output m_len_tvalid, m_len_tdata, m_len_tuser
  );
endinterface

// File: rtl/msg_len_queue.sv
// Measures byte length of each message on a monitored stream and queues {saturated, length}.
// Optional feature macro MSG_LEN_QUEUE_STATS_EN adds msg_count/drop_count statistics outputs.
`timescale 1ns/1ps
module msg_len_queue #(
  parameter int TKEEP_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  msg_len_if.slave    bus,
`ifdef MSG_LEN_QUEUE_STATS_EN
  output logic [15:0] msg_count,
  output logic [15:0] drop_count,
`endif
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state, state_nxt;
  logic [15:0] total, total_nxt;
  logic        sat_flag, sat_nxt;
  logic [16:0] acc;
  logic        acc_sat;
  logic        beat, push;
  logic [16:0] push_entry;

  logic [16:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_ok, drop;

  function automatic logic [15:0] popcount(input logic [TKEEP_WIDTH-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) c = c + {15'd0, k[i]};
    return c;
  endfunction

  // Returns {saturated, value}, clamping the sum at 16'hFFFF.
  function automatic logic [16:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? {1'b1, 16'hFFFF} : {1'b0, s[15:0]};
  endfunction

  assign beat = bus.s_tvalid && bus.s_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      total    <= '0;
      sat_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      total    <= total_nxt;
      sat_flag <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    total_nxt  = total;
    sat_nxt    = sat_flag;
    push       = 1'b0;
    push_entry = '0;
    acc        = sat_add((state == ACCUM) ? total : 16'd0, popcount(bus.s_tkeep));
    acc_sat    = acc[16] | ((state == ACCUM) & sat_flag);
    if (beat) begin
      if (bus.s_tlast) begin
        push       = 1'b1;
        push_entry = {acc_sat, acc[15:0]};
        state_nxt  = IDLE;
        total_nxt  = '0;
        sat_nxt    = 1'b0;
      end else begin
        state_nxt  = ACCUM;
        total_nxt  = acc[15:0];
        sat_nxt    = acc_sat;
      end
    end
  end

  // Length FIFO: extra pointer MSB separates full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.m_len_tready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)     rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (drop)    overflow <= 1'b1;
    end
  end

  // Storage is not reset, so the output is masked to zero while the queue is empty.
  assign bus.m_len_tvalid = !empty;
  assign bus.m_len_tdata  = empty ? 16'd0 : mem[rd_ptr[AW-1:0]][15:0];
  assign bus.m_len_tuser  = empty ? 1'b0  : mem[rd_ptr[AW-1:0]][16];

`ifdef MSG_LEN_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) msg_count  <= msg_count + 16'd1;
      if (drop)    drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule
